// File: rtl/alu_4_pkg.sv
// Shared defaults and the word record exchanged between the assembler and
// its output buffer.
package alu_4_pkg;

  localparam int LAT_DEF     = 7;
  localparam int NIBBLES_DEF = 4;
  localparam int DEPTH_DEF   = 2;

  localparam int WORD_W = 4 * NIBBLES_DEF;
  localparam int LEN_W  = $clog2(NIBBLES_DEF + 1);

  // One assembled word: data (nibble 0 in the low bits), final carry, nibble count.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              carry;
    logic [LEN_W-1:0]  len;
  } word_t;

endpackage

// File: rtl/alu_4_word_fifo.sv
// Small circular FIFO of word records.
// Handshake: a push is taken at a rising edge where push_valid and push_ready
// are both high; push_ready is high when not full or when the head is leaving
// at the same edge. A pop happens at a rising edge where pop_valid and
// pop_ready are both high. pop_data is zero whenever the FIFO is empty.
module alu_4_word_fifo
  import alu_4_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_valid,
  output logic  push_ready,
  input  word_t push_data,
  output logic  pop_valid,
  input  logic  pop_ready,
  output word_t pop_data,
  output logic  full,
  output logic  empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  word_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push_fire;
  logic           pop_fire;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign pop_valid  = !empty;
  assign pop_fire   = pop_valid && pop_ready;
  assign push_ready = !full || pop_fire;
  assign push_fire  = push_valid && push_ready;
  assign pop_data   = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= next_ptr(wr_ptr);
      if (pop_fire)  rd_ptr <= next_ptr(rd_ptr);
      if (push_fire && !pop_fire)      count <= count + 1'b1;
      else if (pop_fire && !push_fire) count <= count - 1'b1;
    end
  end

  // Storage; contents are only visible through a valid head, so no reset.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_4_word_collector.sv
// Collects ALU result nibbles into words. The issue strobes are delayed by
// the ALU latency so each result nibble is captured in the edge where it is
// actually present on Z/Carry_out; finished words go to a small output FIFO.
// The ALU is never stalled: a word that finds the FIFO full is dropped and
// flagged on the sticky ovf output.
module alu_4_word_collector
  import alu_4_pkg::*;
#(
  parameter int LAT     = LAT_DEF,
  parameter int NIBBLES = NIBBLES_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue_valid,
  input  logic                         issue_last,
  input  logic [3:0]                   Z,
  input  logic                         Carry_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*NIBBLES-1:0]         out_data,
  output logic                         out_carry,
  output logic [$clog2(NIBBLES+1)-1:0] out_len,
  output logic                         ovf,
  output logic                         len_err
);

  // The word record type is sized for the package defaults; NIBBLES must match.
  localparam int DW = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int LW = $clog2(NIBBLES + 1);

  logic [LAT-1:0] dly_valid;
  logic [LAT-1:0] dly_last;
  logic           d_valid;
  logic           d_last;
  logic [CW-1:0]  cnt;
  logic [DW-1:0]  slots;
  logic [DW-1:0]  asm_word;
  logic           complete;
  word_t          push_rec;
  word_t          head;
  logic           push_ready;
  logic           fifo_full;
  logic           fifo_empty;

  assign d_valid  = dly_valid[LAT-1];
  assign d_last   = dly_last[LAT-1];
  assign complete = d_valid && (d_last || (cnt == CW'(NIBBLES - 1)));

  // Issue strobe delay line matching the ALU latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_valid <= '0;
      dly_last  <= '0;
    end else begin
      dly_valid[0] <= issue_valid;
      dly_last[0]  <= issue_last;
      for (int i = 1; i < LAT; i++) begin
        dly_valid[i] <= dly_valid[i-1];
        dly_last[i]  <= dly_last[i-1];
      end
    end
  end

  // Current slots with this edge's nibble dropped into position cnt; upper slots stay zero.
  always_comb begin
    asm_word = slots;
    asm_word[4*cnt +: 4] = Z;
  end

  // Record offered to the FIFO when a word completes.
  always_comb begin
    push_rec       = '0;
    push_rec.data  = asm_word;
    push_rec.carry = Carry_out;
    push_rec.len   = LW'(cnt) + 1'b1;
  end

  // Nibble assembly; idle edges leave the partial word untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      slots <= '0;
    end else if (d_valid) begin
      if (complete) begin
        cnt   <= '0;
        slots <= '0;
      end else begin
        cnt   <= cnt + 1'b1;
        slots <= asm_word;
      end
    end
  end

  // Sticky error flags: dropped word, and word closed by length instead of issue_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf     <= 1'b0;
      len_err <= 1'b0;
    end else begin
      if (complete && !push_ready) ovf     <= 1'b1;
      if (complete && !d_last)     len_err <= 1'b1;
    end
  end

  alu_4_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (complete),
    .push_ready (push_ready),
    .push_data  (push_rec),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // A word can only be refused when the buffer is full and not draining.
  always_ff @(posedge clk) begin
    if (rst_n && complete && !push_ready) begin
      assert (fifo_full && !out_ready)
        else $error("word refused while buffer had room");
    end
  end

  assign out_data  = fifo_empty ? '0 : head.data;
  assign out_carry = fifo_empty ? 1'b0 : head.carry;
  assign out_len   = fifo_empty ? '0 : head.len;

endmodule

// File: tb/tb_alu_4_word_collector.sv
module tb_alu_4_word_collector;

  localparam int LAT   = 7;
  localparam int NIB   = 4;
  localparam int DEPTH = 2;
  localparam int DW    = 4 * NIB;
  localparam int LW    = 3;
  localparam int W     = DW + 1 + LW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic          issue_last;
  logic [3:0]    z;
  logic          carry_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_carry;
  logic [LW-1:0] out_len;
  logic          ovf;
  logic          len_err;

  always #5 clk = ~clk;

  alu_4_word_collector #(
    .LAT     (LAT),
    .NIBBLES (NIB),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_last  (issue_last),
    .Z           (z),
    .Carry_out   (carry_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_carry   (out_carry),
    .out_len     (out_len),
    .ovf         (ovf),
    .len_err     (len_err)
  );

  // ---------------- reference model state ----------------
  logic [1:0]   pipe_q[$];   // {valid,last} of the op issued LAT edges ago at the front
  logic [4:0]   res_q[$];    // ALU behaviour: {carry,z} result appears LAT edges after issue
  logic [3:0]   nib_q[$];    // nibbles of the word being assembled
  logic [W-1:0] exp_q[$];    // expected FIFO contents {data, carry, len}
  logic         m_ovf;
  logic         m_len_err;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    for (int i = 0; i < LAT; i++) pipe_q.push_back(2'b00);
    nib_q.delete();
    exp_q.delete();
    m_ovf     = 1'b0;
    m_len_err = 1'b0;
  endtask

  // Effect of one rising edge, from the current inputs.
  task automatic model_edge();
    logic [1:0]    d;
    logic [DW-1:0] data;
    logic [W-1:0]  rec;
    int            len;
    d = pipe_q.pop_front();
    pipe_q.push_back({issue_valid, issue_last});
    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    if (d[1]) begin
      nib_q.push_back(z);
      if (d[0] || nib_q.size() == NIB) begin
        data = '0;
        for (int i = 0; i < nib_q.size(); i++) data = data | (DW'(nib_q[i]) << (4 * i));
        len = nib_q.size();
        rec = {data, carry_out, LW'(len)};
        if (!d[0]) m_len_err = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back(rec);
        else m_ovf = 1'b1;
        nib_q.delete();
      end
    end
  endtask

  task automatic compare_outputs();
    logic [W-1:0] h;
    h = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("out_data",  32'(out_data),  32'(h[W-1 -: DW]));
    check("out_carry", 32'(out_carry), 32'(h[LW]));
    check("out_len",   32'(out_len),   32'(h[LW-1:0]));
    check("ovf",       32'(ovf),       32'(m_ovf));
    check("len_err",   32'(len_err),   32'(m_len_err));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: apply an issue (with its eventual ALU result), advance, compare.
  task automatic step(input logic iv, input logic il, input logic [3:0] zv, input logic cv);
    logic [4:0] r;
    issue_valid = iv;
    issue_last  = il;
    res_q.push_back({cv, zv});
    r = res_q.pop_front();
    carry_out = r[4];
    z         = r[3:0];
    if (rst_n) model_edge();
    else model_reset();
    @(posedge clk);
    #1;
    edge_n++;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 4'($urandom_range(15)), 1'($urandom_range(1)));
  endtask

  // Reset asserted between edges, held over one edge, released after it.
  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    step(1'b0, 1'b0, 4'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          n;
    logic [15:0] nibs;
    logic        last;
    logic        carry;
    logic [15:0] exp_data;
    logic [2:0]  exp_len;
    logic        exp_carry;
    logic        exp_len_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int last_edge;
    int seen;

    vecs[0] = '{4, 16'h4321, 1'b1, 1'b0, 16'h4321, 3'd4, 1'b0, 1'b0};
    vecs[1] = '{2, 16'h005A, 1'b1, 1'b1, 16'h005A, 3'd2, 1'b1, 1'b0};
    vecs[2] = '{1, 16'h000F, 1'b1, 1'b1, 16'h000F, 3'd1, 1'b1, 1'b0};
    vecs[3] = '{3, 16'h09B6, 1'b1, 1'b0, 16'h09B6, 3'd3, 1'b0, 1'b0};
    vecs[4] = '{4, 16'h8E1D, 1'b0, 1'b1, 16'h8E1D, 3'd4, 1'b1, 1'b1};

    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    z           = 4'h0;
    carry_out   = 1'b0;
    out_ready   = 1'b1;
    model_reset();
    res_q.delete();
    for (int i = 0; i < LAT; i++) res_q.push_back(5'($urandom_range(31)));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    rst_n = 1'b1;
    idle(2);

    // Table: one word per vector, latency and contents checked against constants.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++)
        step(1'b1, (i == vecs[v].n - 1) && vecs[v].last, vecs[v].nibs[4*i +: 4],
             (i == vecs[v].n - 1) ? vecs[v].carry : 1'($urandom_range(1)));
      last_edge = edge_n;
      for (int k = 0; k < 30 && !out_valid; k++) idle(1);
      check("vec_latency", 32'(edge_n - last_edge), 32'(LAT));
      check("vec_data",    32'(out_data),  32'(vecs[v].exp_data));
      check("vec_len",     32'(out_len),   32'(vecs[v].exp_len));
      check("vec_carry",   32'(out_carry), 32'(vecs[v].exp_carry));
      check("vec_len_err", 32'(len_err),   32'(vecs[v].exp_len_err));
      idle(3);
    end

    // Gapped issue: nibbles at relative edges 0,3,4,9 form one word.
    async_reset();
    idle(1);
    begin
      int k;
      logic [3:0] val;
      val = 4'h1;
      for (int t = 0; t < 10; t++) begin
        if (t == 0 || t == 3 || t == 4 || t == 9) begin
          step(1'b1, t == 9, val, 1'b0);
          val = val + 1'b1;
        end else begin
          idle(1);
        end
      end
      last_edge = edge_n;
      seen = 0;
      k = 0;
      while (k < 30 && !out_valid) begin idle(1); k++; end
      check("gap_latency", 32'(edge_n - last_edge), 32'(LAT));
      check("gap_data",    32'(out_data), 32'h4321);
      for (int i = 0; i < 15; i++) begin
        if (out_valid) seen++;
        idle(1);
      end
      check("gap_word_count", 32'(seen), 32'd1);
    end

    // Overflow: three single-nibble words with the consumer stalled.
    out_ready = 1'b0;
    step(1'b1, 1'b1, 4'h1, 1'b0);
    step(1'b1, 1'b1, 4'h2, 1'b1);
    step(1'b1, 1'b1, 4'h3, 1'b0);
    idle(LAT + 2);
    check("ovf_set",     32'(ovf),      32'd1);
    check("ovf_head",    32'(out_data), 32'h0001);
    out_ready = 1'b1;
    idle(1);
    check("ovf_second",  32'(out_data), 32'h0002);
    check("ovf_carry2",  32'(out_carry), 32'd1);
    idle(1);
    check("ovf_drained", 32'(out_valid), 32'd0);
    check("ovf_sticky",  32'(ovf),       32'd1);

    // Reset in the middle of a partially issued word: nothing may come out.
    step(1'b1, 1'b0, 4'h7, 1'b0);
    step(1'b1, 1'b0, 4'h8, 1'b0);
    idle(2);
    async_reset();
    check("rst_ovf_clr", 32'(ovf), 32'd0);
    seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      idle(1);
      if (out_valid) seen++;
    end
    check("rst_no_output", 32'(seen), 32'd0);

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(9) < 7);
      if ($urandom_range(999) == 0) async_reset();
      else step(1'($urandom_range(1)), ($urandom_range(9) < 3),
                4'($urandom_range(15)), 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
